// File: rtl/perceptron_train_seq.sv
// Training sequencer: replays a host-loaded sample memory into the perceptron
// epoch by epoch, counting mismatches until an error-free epoch or budget end.
module perceptron_train_seq #(
    parameter int NUM_SAMPLES = 8,
    parameter int IN_W        = 7,
    parameter int SETTLE      = 2,
    parameter int EPOCH_W     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_en,
    input  logic [$clog2(NUM_SAMPLES)-1:0] load_addr,
    input  logic [IN_W:0]                  load_data,
    input  logic [7:0]                     threshold_in,
    input  logic [EPOCH_W-1:0]             max_epochs,
    input  logic                           start,
    output logic [IN_W-1:0]                pcp_in,
    output logic                           pcp_exp_res,
    output logic [7:0]                     pcp_threshold,
    input  logic [1:0]                     pcp_result,
    output logic                           busy,
    output logic                           done,
    output logic                           converged,
    output logic [EPOCH_W-1:0]             epoch_cnt,
    output logic [7:0]                     err_cnt
);
    localparam int AW  = $clog2(NUM_SAMPLES);
    localparam int WCW = $clog2(SETTLE + 1);
    localparam logic [AW-1:0]  LAST_IDX  = AW'(NUM_SAMPLES - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE, PRESENT, WAIT, CAPTURE, EPOCH_END, FIN
    } state_t;

    state_t               state;
    logic [IN_W:0]        mem [NUM_SAMPLES];
    logic [AW-1:0]        idx;
    logic [WCW-1:0]       wait_cnt;
    logic [EPOCH_W-1:0]   max_lat;
    logic [EPOCH_W-1:0]   epoch_inc;
    logic                 err_flag;
    logic                 unused_pred;

    // The prediction bit is not needed for training bookkeeping.
    assign unused_pred = pcp_result[0];
    assign epoch_inc   = epoch_cnt + 1'b1;

    // Memory has no reset so it can map to RAM and survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (load_en && state == IDLE)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            wait_cnt      <= '0;
            max_lat       <= '0;
            err_flag      <= 1'b0;
            pcp_in        <= '0;
            pcp_exp_res   <= 1'b0;
            pcp_threshold <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            converged     <= 1'b0;
            epoch_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    pcp_in      <= '0;
                    pcp_exp_res <= 1'b0;
                    if (start) begin
                        pcp_threshold <= threshold_in;
                        max_lat       <= max_epochs;
                        epoch_cnt     <= '0;
                        err_cnt       <= '0;
                        converged     <= 1'b0;
                        err_flag      <= 1'b0;
                        idx           <= '0;
                        if (max_epochs == '0) begin
                            state <= FIN;
                        end else begin
                            state <= PRESENT;
                            busy  <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    {pcp_exp_res, pcp_in} <= mem[idx];
                    wait_cnt              <= '0;
                    state                 <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST)
                        state <= CAPTURE;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                CAPTURE: begin
                    if (pcp_result[1]) begin
                        err_flag <= 1'b1;
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state <= EPOCH_END;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= PRESENT;
                    end
                end
                EPOCH_END: begin
                    epoch_cnt <= epoch_inc;
                    if (!err_flag || epoch_inc == max_lat) begin
                        converged   <= !err_flag;
                        state       <= FIN;
                        busy        <= 1'b0;
                        pcp_in      <= '0;
                        pcp_exp_res <= 1'b0;
                    end else begin
                        err_flag <= 1'b0;
                        idx      <= '0;
                        state    <= PRESENT;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_train_seq.sv
// Directed bench for perceptron_train_seq with a behavioural perceptron stub
// whose mismatch pattern is selected per scenario.
module tb_perceptron_train_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_en = 1'b0;
    logic [2:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic [7:0] threshold_in = '0;
    logic [7:0] max_epochs = '0;
    logic       start = 1'b0;
    logic [6:0] pcp_in;
    logic       pcp_exp_res;
    logic [7:0] pcp_threshold;
    logic [1:0] pcp_result;
    logic       busy, done, converged;
    logic [7:0] epoch_cnt, err_cnt;

    int vectors = 0;
    int miscompares = 0;
    int mode = 0;            // 0: never mismatch, 1: always, 2: sample 3 in first two epochs
    int seen3 = 0;
    int base3 = 0;
    logic prev_match = 1'b0;
    logic match;
    logic [7:0] exp_mem [8];

    perceptron_train_seq dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .threshold_in(threshold_in), .max_epochs(max_epochs),
        .start(start), .pcp_in(pcp_in), .pcp_exp_res(pcp_exp_res),
        .pcp_threshold(pcp_threshold), .pcp_result(pcp_result), .busy(busy),
        .done(done), .converged(converged), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Sample 3 carries feature 44; count each presentation window it occupies.
    assign match = (pcp_in == 7'd44);
    always @(posedge clk) begin
        prev_match <= match;
        if (prev_match && !match) seen3 <= seen3 + 1;
    end
    assign pcp_result[1] = (mode == 1) ? 1'b1 :
                           (mode == 2) ? (match && (seen3 - base3) < 2) : 1'b0;
    assign pcp_result[0] = pcp_in[0];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = 3'(a); load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic do_start(input logic [7:0] me, input logic [7:0] th);
        @(negedge clk);
        max_epochs = me; threshold_in = th; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n, output bit busy_seen);
        n = 0; busy_seen = 0;
        while (!done && n < bound) begin
            tick(1); n++;
            if (busy) busy_seen = 1;
        end
        vectors++;
        if (!done) begin
            $display("FAIL done_timeout: no done within %0d cycles", bound);
            miscompares++;
        end
    endtask

    // Called right after do_start; ends on the capture edge of the last sample.
    task automatic check_stream(input string tag);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            vectors++;
            if ({pcp_exp_res, pcp_in} !== exp_mem[i]) begin
                $display("FAIL %s_present[%0d]: got %h expected %h", tag, i, {pcp_exp_res, pcp_in}, exp_mem[i]);
                miscompares++;
            end
            tick(3);
            vectors++;
            if ({pcp_exp_res, pcp_in} !== exp_mem[i]) begin
                $display("FAIL %s_hold[%0d]: got %h expected %h", tag, i, {pcp_exp_res, pcp_in}, exp_mem[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, converged, epoch_cnt, err_cnt, pcp_in, pcp_exp_res, pcp_threshold} !== '0) begin
            $display("FAIL reset_async: outputs %h expected 0",
                     {busy, done, converged, epoch_cnt, err_cnt, pcp_in, pcp_exp_res, pcp_threshold});
            miscompares++;
        end
        tick(2);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            vectors++;
            if ({busy, done} !== 2'b00) begin
                $display("FAIL reset_idle: busy/done %b expected 00", {busy, done});
                miscompares++;
            end
        end
    endtask

    task automatic test_single_epoch();
        for (int i = 0; i < 8; i++) load(i, {1'(i), 7'(i * 13 + 5)});
        mode = 0;
        do_start(8'd5, 8'h5A);
        vectors++;
        if (pcp_threshold !== 8'h5A || busy !== 1'b1) begin
            $display("FAIL start_latch: thr %h busy %b expected 5a 1", pcp_threshold, busy);
            miscompares++;
        end
        check_stream("single");
        tick(1);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL fin_edge: done %b busy %b expected 0 0", done, busy);
            miscompares++;
        end
        tick(1);
        vectors++;
        if ({done, converged, epoch_cnt, err_cnt, pcp_in} !== {1'b1, 1'b1, 8'd1, 8'd0, 7'd0}) begin
            $display("FAIL single_done: done %b conv %b ep %0d err %0d in %h expected 1 1 1 0 0",
                     done, converged, epoch_cnt, err_cnt, pcp_in);
            miscompares++;
        end
        tick(1);
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL done_pulse: done %b expected 0", done);
            miscompares++;
        end
    endtask

    task automatic test_partial_errors();
        int n; bit bs;
        mode = 2; base3 = seen3;
        do_start(8'd10, 8'h33);
        threshold_in = 8'hCC; max_epochs = 8'd1;
        wait_done(400, n, bs);
        vectors++;
        if (n != 100 || {converged, epoch_cnt, err_cnt, pcp_threshold} !== {1'b1, 8'd3, 8'd2, 8'h33}) begin
            $display("FAIL partial_run: cyc %0d conv %b ep %0d err %0d thr %h expected 100 1 3 2 33",
                     n, converged, epoch_cnt, err_cnt, pcp_threshold);
            miscompares++;
        end
    endtask

    task automatic test_always_mismatch();
        int n; bit bs;
        mode = 1;
        do_start(8'd2, 8'h10);
        wait_done(200, n, bs);
        vectors++;
        if (n != 67 || {converged, epoch_cnt, err_cnt} !== {1'b0, 8'd2, 8'd16}) begin
            $display("FAIL budget_run: cyc %0d conv %b ep %0d err %0d expected 67 0 2 16",
                     n, converged, epoch_cnt, err_cnt);
            miscompares++;
        end
        do_start(8'd40, 8'h10);
        wait_done(2000, n, bs);
        vectors++;
        if (n != 1321 || {converged, epoch_cnt, err_cnt} !== {1'b0, 8'd40, 8'd255}) begin
            $display("FAIL saturate_run: cyc %0d conv %b ep %0d err %0d expected 1321 0 40 255",
                     n, converged, epoch_cnt, err_cnt);
            miscompares++;
        end
    endtask

    task automatic test_zero_budget();
        int n; bit bs;
        mode = 0;
        do_start(8'd0, 8'h77);
        wait_done(10, n, bs);
        vectors++;
        if (n != 1 || bs || {converged, epoch_cnt, err_cnt, pcp_threshold} !== {1'b0, 8'd0, 8'd0, 8'h77}) begin
            $display("FAIL zero_budget: cyc %0d busy_seen %b conv %b ep %0d err %0d thr %h expected 1 0 0 0 0 77",
                     n, bs, converged, epoch_cnt, err_cnt, pcp_threshold);
            miscompares++;
        end
    endtask

    task automatic test_ignored_inputs();
        int n; bit bs;
        mode = 0;
        do_start(8'd5, 8'h21);
        tick(10);
        @(negedge clk);
        start = 1'b1; load_en = 1'b1; load_addr = 3'd2; load_data = 8'hFF;
        tick(3);
        start = 1'b0; load_en = 1'b0;
        wait_done(100, n, bs);
        vectors++;
        if (n != 21 || {converged, epoch_cnt, err_cnt} !== {1'b1, 8'd1, 8'd0}) begin
            $display("FAIL busy_ignore: cyc %0d conv %b ep %0d err %0d expected 21 1 1 0",
                     n, converged, epoch_cnt, err_cnt);
            miscompares++;
        end
        do_start(8'd5, 8'h21);
        check_stream("readback");
        tick(2);
    endtask

    task automatic test_back_to_back_reset();
        mode = 1;
        do_start(8'd5, 8'h42);
        tick(35);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, converged, epoch_cnt, err_cnt, pcp_in, pcp_exp_res, pcp_threshold} !== '0) begin
            $display("FAIL midrun_reset: outputs %h expected 0",
                     {busy, done, converged, epoch_cnt, err_cnt, pcp_in, pcp_exp_res, pcp_threshold});
            miscompares++;
        end
        tick(1);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL post_reset_quiet[%0d]: done %b busy %b expected 0 0", i, done, busy);
                miscompares++;
            end
        end
        mode = 0;
        do_start(8'd5, 8'h42);
        check_stream("restart");
        tick(2);
        vectors++;
        if ({done, converged, epoch_cnt, err_cnt} !== {1'b1, 1'b1, 8'd1, 8'd0}) begin
            $display("FAIL restart_done: done %b conv %b ep %0d err %0d expected 1 1 1 0",
                     done, converged, epoch_cnt, err_cnt);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_single_epoch();
        test_partial_errors();
        test_always_mismatch();
        test_zero_budget();
        test_ignored_inputs();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
